// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if -- pixel stream in, 3x3 window out.
//   pix_valid / pix_in        : raster-order 8-bit pixels (producer -> window gen)
//   win_valid                 : one-cycle strobe, window below is valid
//   Out_Win_1 .. Out_Win_9    : 3x3 window, row-major, Out_Win_1 = top-left
//   frame_done                : pulses with the last window of a frame
// modport master : pixel producer / window consumer side
// modport slave  : conv_window_gen side
interface conv_window_gen_if;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       win_valid;
    logic [7:0] Out_Win_1, Out_Win_2, Out_Win_3;
    logic [7:0] Out_Win_4, Out_Win_5, Out_Win_6;
    logic [7:0] Out_Win_7, Out_Win_8, Out_Win_9;
    logic       frame_done;

    modport master (
        output pix_valid, pix_in,
        input  win_valid, frame_done,
        input  Out_Win_1, Out_Win_2, Out_Win_3,
        input  Out_Win_4, Out_Win_5, Out_Win_6,
        input  Out_Win_7, Out_Win_8, Out_Win_9
    );

    modport slave (
        input  pix_valid, pix_in,
        output win_valid, frame_done,
        output Out_Win_1, Out_Win_2, Out_Win_3,
        output Out_Win_4, Out_Win_5, Out_Win_6,
        output Out_Win_7, Out_Win_8, Out_Win_9
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen -- 3x3 sliding-window generator for a raster pixel stream.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : conv_window_gen_if.slave (pixel input, window output, frame_done)
// Two line buffers hold rows r-1 and r-2 at the current column. A two-column
// shift window holds columns c-2 and c-1 of the three rows; the third column
// comes straight from the line buffers and the incoming pixel. The output
// registers load only when a full window exists, so they hold between windows.
module conv_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [0:0]            state;
    logic [7:0]            lb1 [IMG_W];   // row r-1
    logic [7:0]            lb2 [IMG_W];   // row r-2
    logic [2:0][1:0][7:0]  win;           // [win row][0 = col c-2, 1 = col c-1]
    logic [8:0][7:0]       owin;          // owin[8] = Out_Win_1
    logic                  win_valid_q;
    logic                  frame_done_q;

    logic       accept, col_end, frame_end, emit;
    logic [7:0] up1, up2;

    assign accept    = bus.pix_valid;
    assign col_end   = (col == COL_LAST);
    assign frame_end = col_end && (row == ROW_LAST);
    // STREAM means row >= 2 of the current frame, so both line buffers are
    // guaranteed to hold this frame's data; col >= 2 keeps windows in-row.
    assign emit      = accept && (state == STREAM) && (col >= COL_TWO);
    assign up1       = lb1[col];
    assign up2       = lb2[col];

    // Datapath storage carries no reset: every entry is rewritten before it
    // can reach a window (rows 0/1 refill the buffers, cols 0/1 the shifter).
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col]   <= up1;
            lb1[col]   <= bus.pix_in;
            win[0][0]  <= win[0][1];
            win[0][1]  <= up2;
            win[1][0]  <= win[1][1];
            win[1][1]  <= up1;
            win[2][0]  <= win[2][1];
            win[2][1]  <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                if (state == FILL && row == ROW_ONE)
                    state <= STREAM;
                else if (state == STREAM && row == ROW_LAST)
                    state <= FILL;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            owin         <= '0;
        end else begin
            win_valid_q  <= emit;
            frame_done_q <= emit && frame_end;
            if (emit)
                owin <= {win[0][0], win[0][1], up2,
                         win[1][0], win[1][1], up1,
                         win[2][0], win[2][1], bus.pix_in};
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.Out_Win_1  = owin[8];
    assign bus.Out_Win_2  = owin[7];
    assign bus.Out_Win_3  = owin[6];
    assign bus.Out_Win_4  = owin[5];
    assign bus.Out_Win_5  = owin[4];
    assign bus.Out_Win_6  = owin[3];
    assign bus.Out_Win_7  = owin[2];
    assign bus.Out_Win_8  = owin[1];
    assign bus.Out_Win_9  = owin[0];
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: the driver stores each accepted pixel
// in an image array and queues the expected window; an independent negedge
// monitor pops and compares whenever win_valid is seen.
module tb_conv_window_gen;
    localparam int W = 8;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if bus();

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct { logic [71:0] w; bit fd; int cyc; } exp_t;
    typedef struct { logic [71:0] w; bit fd; } win_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q[$];
    win_t        log_q[$];
    win_t        ref_log[$];
    int          img [H][W];
    int          mr = 0, mc = 0;
    int          wt [9];
    logic [71:0] last_w = '0;
    exp_t        e;
    logic [71:0] dw;

    assign dw = {bus.Out_Win_1, bus.Out_Win_2, bus.Out_Win_3,
                 bus.Out_Win_4, bus.Out_Win_5, bus.Out_Win_6,
                 bus.Out_Win_7, bus.Out_Win_8, bus.Out_Win_9};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Weighted sum as a downstream 3x3 convolution would form it.
    function automatic int wsum(logic [71:0] v);
        int s = 0;
        for (int k = 0; k < 9; k++) s += wt[k] * int'(v[71-8*k -: 8]);
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            last_w = '0;
        end else if (bus.win_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_window", 72'd1, 72'd0);
            end else begin
                e = q.pop_front();
                chk("window", dw, e.w);
                chk("frame_done", 72'(bus.frame_done), 72'(e.fd));
                chk("latency", 72'(cyc), 72'(e.cyc));
                chk("conv_sum", 72'(wsum(dw)), 72'(wsum(e.w)));
            end
            log_q.push_back('{dw, bus.frame_done});
            last_w = dw;
        end else begin
            chk("hold", dw, last_w);
            chk("frame_done_idle", 72'(bus.frame_done), 72'd0);
        end
    end

    task automatic idle(int n);
        bus.pix_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(int p, int gap);
        logic [71:0] w;
        repeat (gap) begin bus.pix_valid = 1'b0; @(posedge clk); #1; end
        bus.pix_valid = 1'b1;
        bus.pix_in    = p[7:0];
        img[mr][mc]   = p & 255;
        if (mr >= 2 && mc >= 2) begin
            w = '0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    w = {w[63:0], 8'(img[mr-2+dr][mc-2+dc])};
            q.push_back('{w, (mr == H-1 && mc == W-1), cyc + 1});
        end
        mc++;
        if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
        @(posedge clk); #1;
    endtask

    // kind 0: ramp, 1: inverted ramp, 2: random pixels
    task automatic frame(int kind, int maxgap);
        int p;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (kind == 0)      p = 8*r + c;
                else if (kind == 1) p = 255 - (8*r + c);
                else                p = int'($urandom_range(255));
                send(p, (maxgap > 0) ? int'($urandom_range(maxgap)) : 0);
            end
    endtask

    task automatic check_ramp_log(string tag);
        chk({tag, "_count"}, 72'(log_q.size()), 72'd36);
        if (log_q.size() >= 36) begin
            chk({tag, "_first"}, log_q[0].w, 72'h000102_08090a_101112);
            chk({tag, "_last"}, log_q[35].w, 72'h2d2e2f_353637_3d3e3f);
            chk({tag, "_last_fd"}, 72'(log_q[35].fd), 72'd1);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_win_valid"}, 72'(bus.win_valid), 72'd0);
        chk({tag, "_frame_done"}, 72'(bus.frame_done), 72'd0);
        chk({tag, "_windows"}, dw, 72'd0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        for (int k = 0; k < 9; k++) wt[k] = int'($urandom_range(15)) - 8;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // ramp frame, continuous
        frame(0, 0);
        idle(3);
        check_ramp_log("ramp");
        ref_log = log_q;

        // same frame with random bubbles
        log_q.delete();
        frame(0, 5);
        idle(3);
        chk("gaps_count", 72'(log_q.size()), 72'(ref_log.size()));
        for (int i = 0; i < ref_log.size() && i < log_q.size(); i++)
            chk("gaps_window", log_q[i].w, ref_log[i].w);

        // back-to-back frames, second inverted
        log_q.delete();
        frame(0, 0);
        frame(1, 0);
        idle(3);
        chk("b2b_count", 72'(log_q.size()), 72'd72);
        if (log_q.size() > 36)
            chk("b2b_first_second", log_q[36].w, 72'hfffefd_f7f6f5_efeeed);

        // reset mid-frame, then a fresh ramp frame
        log_q.delete();
        for (int i = 0; i < 30; i++) send(i, 0);
        idle(1);
        chk("pre_reset_drained", 72'(q.size()), 72'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle(2);
        rst_n = 1'b1;
        mr = 0; mc = 0;
        q.delete();
        log_q.delete();
        idle(1);
        frame(0, 0);
        idle(3);
        check_ramp_log("post_reset");

        // random frames with random gaps against the model
        log_q.delete();
        for (int f = 0; f < 4; f++) frame(2, 5);
        idle(3);
        chk("random_count", 72'(log_q.size()), 72'd144);
        chk("scoreboard_empty", 72'(q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
